// File: rtl/data_reg_bank_stream.sv
// N-entry register bank with single/parallel load, per-entry dirty flags and a valid/ready stream-out port.
// Optional byte-enable write masking when DRB_WRITE_MASK_EN is defined (adds wr_be input).
module data_reg_bank_stream #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int AW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_bus,
  input  logic [W-1:0]   data_in,
  input  logic [AW-1:0]  wr_addr,
  input  logic           wr_en,
  input  logic           wr_all,
`ifdef DRB_WRITE_MASK_EN
  input  logic [W/8-1:0] wr_be,
`endif
  input  logic           rd_start,
  output logic [N*W-1:0] out_bus,
  output logic [N-1:0]   dirty,
  output logic [W-1:0]   stream_data,
  output logic [AW-1:0]  stream_idx,
  output logic           stream_valid,
  input  logic           stream_ready,
  output logic           stream_last,
  output logic           busy,
  output logic           done,
  output logic           wr_err
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [AW:0]   NUM  = (AW+1)'(N);
  localparam logic [AW-1:0] LAST = AW'(N-1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t        state_q;
  logic [W-1:0]  entry_q [N];
  logic [W-1:0]  entry_d [N];
  logic [N-1:0]  dirty_q, dirty_d;
  logic [W-1:0]  stream_data_q;
  logic [AW-1:0] stream_idx_q;
  logic          stream_valid_q;
  logic          done_q;
  logic          wr_err_q;

  logic          addr_ok;
  logic          accept;
  logic [AW-1:0] idx_nxt;
  logic [W-1:0]  nxt_word;

  assign addr_ok = ({1'b0, wr_addr} < NUM);
  assign accept  = (state_q == SEND) && stream_ready;
  assign idx_nxt = stream_idx_q + ONE;

  // Clear on accepted beat first so a same-edge write re-sets the flag.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      entry_d[i] = entry_q[i];
      dirty_d[i] = dirty_q[i];
      if (accept && (stream_idx_q == AW'(i))) dirty_d[i] = 1'b0;
      if (wr_en) begin
        if (addr_ok && (wr_addr == AW'(i))) begin
`ifdef DRB_WRITE_MASK_EN
          for (int b = 0; b < W/8; b++) begin
            if (wr_be[b]) entry_d[i][b*8 +: 8] = data_in[b*8 +: 8];
          end
          if (|wr_be) dirty_d[i] = 1'b1;
`else
          entry_d[i] = data_in;
          dirty_d[i] = 1'b1;
`endif
        end
      end else if (wr_all) begin
        entry_d[i] = in_bus[i*W +: W];
        dirty_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_word = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_nxt == AW'(i)) nxt_word = entry_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) entry_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) entry_q[i] <= entry_d[i];
      dirty_q <= dirty_d;
    end
  end

  // Stream FSM: latches pre-write entry values so writes before latching are streamed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      stream_data_q  <= '0;
      stream_idx_q   <= '0;
      stream_valid_q <= 1'b0;
      done_q         <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= wr_en && !addr_ok;
      case (state_q)
        IDLE: begin
          if (rd_start) begin
            state_q        <= SEND;
            stream_idx_q   <= '0;
            stream_data_q  <= entry_q[0];
            stream_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (stream_ready) begin
            if (stream_idx_q == LAST) begin
              state_q        <= IDLE;
              stream_valid_q <= 1'b0;
              done_q         <= 1'b1;
            end else begin
              stream_idx_q  <= idx_nxt;
              stream_data_q <= nxt_word;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_bus[g*W +: W] = entry_q[g];
  end

  assign dirty        = dirty_q;
  assign stream_data  = stream_data_q;
  assign stream_idx   = stream_idx_q;
  assign stream_valid = stream_valid_q;
  assign stream_last  = stream_valid_q && (stream_idx_q == LAST);
  assign busy         = (state_q == SEND);
  assign done         = done_q;
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_data_reg_bank_stream.sv
// Directed bench for data_reg_bank_stream (N=4, W=32); mask test active when DRB_WRITE_MASK_EN is defined.
module tb_data_reg_bank_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_bus;
  logic [31:0]  data_in;
  logic [1:0]   wr_addr;
  logic         wr_en, wr_all, rd_start, stream_ready;
`ifdef DRB_WRITE_MASK_EN
  logic [3:0]   wr_be;
`endif
  logic [127:0] out_bus;
  logic [3:0]   dirty;
  logic [31:0]  stream_data;
  logic [1:0]   stream_idx;
  logic         stream_valid, stream_last, busy, done, wr_err;

  int total = 0;
  int bad   = 0;

  data_reg_bank_stream #(.N(4), .W(32), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .data_in(data_in),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_all(wr_all),
`ifdef DRB_WRITE_MASK_EN
    .wr_be(wr_be),
`endif
    .rd_start(rd_start), .out_bus(out_bus), .dirty(dirty),
    .stream_data(stream_data), .stream_idx(stream_idx),
    .stream_valid(stream_valid), .stream_ready(stream_ready),
    .stream_last(stream_last), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [1:0] idx, input logic [31:0] data,
                      input logic last);
    check({tag, "_valid"}, {127'd0, stream_valid}, 128'd1);
    check({tag, "_idx"},   {126'd0, stream_idx},   {126'd0, idx});
    check({tag, "_data"},  {96'd0, stream_data},   {96'd0, data});
    check({tag, "_last"},  {127'd0, stream_last},  {127'd0, last});
  endtask

  initial begin
    rst_n = 1'b0; in_bus = '0; data_in = '0; wr_addr = '0;
    wr_en = 1'b0; wr_all = 1'b0; rd_start = 1'b0; stream_ready = 1'b0;
`ifdef DRB_WRITE_MASK_EN
    wr_be = 4'h0;
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Load something, start a stream, then assert reset mid-cycle.
    wr_all = 1'b1; in_bus = {32'h4, 32'h3, 32'h2, 32'h1};
    @(negedge clk);
    wr_all = 1'b0; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("pre_rst_busy", {127'd0, busy}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_bus", out_bus, 128'd0);
    check("rst_dirty", {124'd0, dirty}, 128'd0);
    check("rst_valid", {127'd0, stream_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check("rst_no_done", {127'd0, done}, 128'd0);
    check("rst_sdata", {96'd0, stream_data}, 128'd0);
    rst_n = 1'b1;

    // wr_en beats wr_all in the same cycle.
    wr_en = 1'b1; wr_addr = 2'd2; data_in = 32'hDEADBEEF;
    wr_all = 1'b1; in_bus = {4{32'h99}};
    @(negedge clk);
    wr_en = 1'b0; wr_all = 1'b0;
    check("prio_out_bus", out_bus, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    check("prio_dirty", {124'd0, dirty}, {124'd0, 4'b0100});
    check("prio_wr_err", {127'd0, wr_err}, 128'd0);

    // Full stream with ready held high.
    wr_all = 1'b1; in_bus = {32'h4, 32'h3, 32'h2, 32'h1};
    @(negedge clk);
    wr_all = 1'b0;
    check("all_dirty", {124'd0, dirty}, {124'd0, 4'b1111});
    check("all_out_bus", out_bus, {32'h4, 32'h3, 32'h2, 32'h1});
    rd_start = 1'b1; stream_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("s1_busy", {127'd0, busy}, 128'd1);
    beat("s1_b0", 2'd0, 32'h1, 1'b0);
    @(negedge clk);
    beat("s1_b1", 2'd1, 32'h2, 1'b0);
    check("s1_dirty_b1", {124'd0, dirty}, {124'd0, 4'b1110});
    @(negedge clk);
    beat("s1_b2", 2'd2, 32'h3, 1'b0);
    @(negedge clk);
    beat("s1_b3", 2'd3, 32'h4, 1'b1);
    check("s1_done_early", {127'd0, done}, 128'd0);
    @(negedge clk);
    check("s1_done", {127'd0, done}, 128'd1);
    check("s1_valid_off", {127'd0, stream_valid}, 128'd0);
    check("s1_busy_off", {127'd0, busy}, 128'd0);
    check("s1_dirty_end", {124'd0, dirty}, 128'd0);
    @(negedge clk);
    check("s1_done_pulse", {127'd0, done}, 128'd0);

    // Backpressure on beat 1 for three cycles.
    wr_all = 1'b1;
    @(negedge clk);
    wr_all = 1'b0; rd_start = 1'b1; stream_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    beat("s2_b0", 2'd0, 32'h1, 1'b0);
    @(negedge clk);
    beat("s2_b1", 2'd1, 32'h2, 1'b0);
    stream_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      beat("s2_hold", 2'd1, 32'h2, 1'b0);
    end
    stream_ready = 1'b1;
    @(negedge clk);
    beat("s2_b2", 2'd2, 32'h3, 1'b0);
    @(negedge clk);
    beat("s2_b3", 2'd3, 32'h4, 1'b1);
    @(negedge clk);
    check("s2_done", {127'd0, done}, 128'd1);

    // Writes during a stream.
    wr_all = 1'b1;
    @(negedge clk);
    wr_all = 1'b0; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    beat("s3_b0", 2'd0, 32'h1, 1'b0);
    wr_en = 1'b1; wr_addr = 2'd0; data_in = 32'h77;
    @(negedge clk);
    beat("s3_b1", 2'd1, 32'h2, 1'b0);
    check("s3_dirty0_set_wins", {124'd0, dirty}, {124'd0, 4'b1111});
    wr_addr = 2'd3; data_in = 32'h55;
    @(negedge clk);
    wr_en = 1'b0;
    beat("s3_b2", 2'd2, 32'h3, 1'b0);
    check("s3_dirty_mid", {124'd0, dirty}, {124'd0, 4'b1101});
    @(negedge clk);
    beat("s3_b3", 2'd3, 32'h55, 1'b1);
    @(negedge clk);
    check("s3_done", {127'd0, done}, 128'd1);
    check("s3_dirty_end", {124'd0, dirty}, {124'd0, 4'b0001});
    check("s3_out_bus", out_bus, {32'h55, 32'h3, 32'h2, 32'h77});

`ifdef DRB_WRITE_MASK_EN
    wr_en = 1'b1; wr_addr = 2'd1; data_in = 32'h11223344; wr_be = 4'hF;
    @(negedge clk);
    data_in = 32'hAABBCCDD; wr_be = 4'b0101;
    @(negedge clk);
    wr_en = 1'b0;
    check("mask_entry1", {96'd0, out_bus[63:32]}, {96'd0, 32'h11BB33DD});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
